// File: rtl/dffram_arbiter_if.sv
// Requester and DFFRAM-side bus of the two-port DFFRAM arbiter.
// The slave modport is the arbiter. The master modport is the environment: both requesters plus the RAM macro.
interface dffram_arbiter_if #(
  parameter int AW = 8
);
  logic          REQ0, REQ1;
  logic          WR0, WR1;
  logic [1:0]    SZ0, SZ1;
  logic [AW+1:0] AD0, AD1;
  logic [31:0]   WD0, WD1;
  logic          GNT0, GNT1;
  logic          DONE0, DONE1;
  logic          ERR;
  logic [31:0]   RDATA;
  logic          RAM_EN;
  logic [3:0]    RAM_WE;
  logic [AW-1:0] RAM_A;
  logic [31:0]   RAM_DI;
  logic [31:0]   RAM_DO;

  modport slave (
    input  REQ0, REQ1, WR0, WR1, SZ0, SZ1, AD0, AD1, WD0, WD1, RAM_DO,
    output GNT0, GNT1, DONE0, DONE1, ERR, RDATA, RAM_EN, RAM_WE, RAM_A, RAM_DI
  );

  modport master (
    output REQ0, REQ1, WR0, WR1, SZ0, SZ1, AD0, AD1, WD0, WD1, RAM_DO,
    input  GNT0, GNT1, DONE0, DONE1, ERR, RDATA, RAM_EN, RAM_WE, RAM_A, RAM_DI
  );
endinterface

// File: rtl/dffram_arbiter.sv
// Two-requester front end for a single-port DFFRAM: arbitrates, lane-steers byte/hword/word
// accesses, and rejects misaligned or illegal-size requests without touching the RAM.
module dffram_arbiter #(
  parameter int AW    = 8,
  parameter bit RR_EN = 1'b1
) (
  input logic               CLK,
  input logic               RSTn,
  dffram_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state;
  logic          own;       // port that owns the request in flight
  logic          rr_prio;   // port preferred when both request
  logic          wr_q;
  logic [1:0]    sz_q;
  logic [AW+1:0] ad_q;
  logic [31:0]   wd_q;
  logic          err_q;
  logic          done0_q, done1_q, err_out_q;
  logic [31:0]   rdata_q;

  logic          any_req, grant, pick1;
  logic          sel_wr, sel_bad;
  logic [1:0]    sel_sz;
  logic [AW+1:0] sel_ad;
  logic [31:0]   sel_wd;
  logic [31:0]   rd_shift, rd_aligned;

  function automatic logic is_illegal(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'b00:   is_illegal = 1'b0;
      2'b01:   is_illegal = lo[0];
      2'b10:   is_illegal = (lo != 2'b00);
      default: is_illegal = 1'b1;
    endcase
  endfunction

  assign any_req = bus.REQ0 | bus.REQ1;
  assign pick1   = (bus.REQ0 && bus.REQ1) ? (RR_EN ? rr_prio : 1'b0) : bus.REQ1;
  assign grant   = RSTn && (state == IDLE) && any_req;

  assign sel_wr  = pick1 ? bus.WR1 : bus.WR0;
  assign sel_sz  = pick1 ? bus.SZ1 : bus.SZ0;
  assign sel_ad  = pick1 ? bus.AD1 : bus.AD0;
  assign sel_wd  = pick1 ? bus.WD1 : bus.WD0;
  assign sel_bad = is_illegal(sel_sz, sel_ad[1:0]);

  assign bus.GNT0  = grant & ~pick1;
  assign bus.GNT1  = grant &  pick1;
  assign bus.DONE0 = done0_q;
  assign bus.DONE1 = done1_q;
  assign bus.ERR   = err_out_q;
  assign bus.RDATA = rdata_q;

  // RAM is driven only in ACCESS, so a reset sampled at the end of ACCESS still lets that write land.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block can infer a latch.
    bus.RAM_EN = 1'b0;
    bus.RAM_WE = '0;
    bus.RAM_A  = '0;
    bus.RAM_DI = '0;
    if (state == ACCESS) begin
      bus.RAM_EN = 1'b1;
      bus.RAM_A  = ad_q[AW+1:2];
      if (wr_q) begin
        case (sz_q)
          2'b00:   bus.RAM_WE = 4'b0001 << ad_q[1:0];
          2'b01:   bus.RAM_WE = ad_q[1] ? 4'b1100 : 4'b0011;
          default: bus.RAM_WE = 4'b1111;
        endcase
        bus.RAM_DI = wd_q << {ad_q[1:0], 3'b000};
      end
    end
  end

  assign rd_shift = bus.RAM_DO >> {ad_q[1:0], 3'b000};

  always_comb begin
    case (sz_q)
      2'b00:   rd_aligned = {24'b0, rd_shift[7:0]};
      2'b01:   rd_aligned = {16'b0, rd_shift[15:0]};
      default: rd_aligned = rd_shift;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!RSTn) begin
      state     <= IDLE;
      own       <= 1'b0;
      rr_prio   <= 1'b0;
      wr_q      <= 1'b0;
      sz_q      <= '0;
      ad_q      <= '0;
      wd_q      <= '0;
      err_q     <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err_out_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err_out_q <= 1'b0;
      case (state)
        IDLE: if (any_req) begin
          own     <= pick1;
          rr_prio <= ~pick1;
          wr_q    <= sel_wr;
          sz_q    <= sel_sz;
          ad_q    <= sel_ad;
          wd_q    <= sel_wd;
          err_q   <= sel_bad;
          state   <= sel_bad ? RESP : ACCESS;
        end
        ACCESS: state <= RESP;
        RESP: begin
          if (!err_q && !wr_q) rdata_q <= rd_aligned;
          done0_q   <= ~own;
          done1_q   <=  own;
          err_out_q <= err_q;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dffram_arbiter.sv
// Self-checking bench for dffram_arbiter: a directed vector table, hand-written reset and
// contention sequences, and random traffic scored against a byte-addressed memory model.
module tb_dffram_arbiter;
  localparam int AW = 8;

  logic CLK;
  logic RSTn;
  bit   ram_clear;
  int   checks = 0;
  int   failures = 0;

  dffram_arbiter_if #(.AW(AW)) bus ();
  dffram_arbiter #(.AW(AW), .RR_EN(1'b1)) dut (.CLK(CLK), .RSTn(RSTn), .bus(bus));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // DFFRAM macro: read data appears one clock after the access edge.
  logic [31:0] ram [0:(1<<AW)-1];
  always @(posedge CLK) begin
    if (ram_clear) begin
      for (int i = 0; i < (1<<AW); i++) ram[i] <= '0;
    end else if (bus.RAM_EN) begin
      bus.RAM_DO <= ram[bus.RAM_A];
      for (int l = 0; l < 4; l++)
        if (bus.RAM_WE[l]) ram[bus.RAM_A][8*l +: 8] <= bus.RAM_DI[8*l +: 8];
    end
  end

  // Reference model: plain byte-addressed memory.
  logic [7:0] ref_mem [0:(1<<(AW+2))-1];

  function automatic bit ref_illegal(input logic [1:0] sz, input int ad);
    return (sz == 2'd3) || (sz == 2'd1 && ad % 2 != 0) || (sz == 2'd2 && ad % 4 != 0);
  endfunction

  function automatic logic [31:0] ref_read(input logic [1:0] sz, input int ad);
    logic [31:0] r = '0;
    for (int i = 0; i < (1 << sz); i++) r[8*i +: 8] = ref_mem[ad + i];
    return r;
  endfunction

  task automatic ref_write(input logic [1:0] sz, input int ad, input logic [31:0] wd);
    for (int i = 0; i < (1 << sz); i++) ref_mem[ad + i] = wd[8*i +: 8];
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input bit port, input bit wr, input logic [1:0] sz,
                           input logic [AW+1:0] ad, input logic [31:0] wd);
    if (port) begin
      bus.WR1 = wr; bus.SZ1 = sz; bus.AD1 = ad; bus.WD1 = wd; bus.REQ1 = 1'b1;
    end else begin
      bus.WR0 = wr; bus.SZ0 = sz; bus.AD0 = ad; bus.WD0 = wd; bus.REQ0 = 1'b1;
    end
  endtask

  // Returns with the DUT back in IDLE, just after a rising edge.
  task automatic do_txn(input bit port, input bit wr, input logic [1:0] sz,
                        input logic [AW+1:0] ad, input logic [31:0] wd,
                        output bit granted, output bit got_done, output bit err,
                        output logic [31:0] rdata, output int en_cyc, output int lat,
                        output logic [3:0] we, output logic [AW-1:0] a, output logic [31:0] di);
    granted = 0; got_done = 0; err = 0; rdata = '0; en_cyc = 0; lat = 0;
    we = '0; a = '0; di = '0;
    drive_req(port, wr, sz, ad, wd);
    for (int i = 0; i < 10 && !granted; i++) begin
      @(negedge CLK);
      granted = port ? bus.GNT1 : bus.GNT0;
      @(posedge CLK); #1;
    end
    bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
    for (int c = 1; c <= 8 && granted && !got_done; c++) begin
      @(negedge CLK);
      if (bus.RAM_EN) begin en_cyc = c; we = bus.RAM_WE; a = bus.RAM_A; di = bus.RAM_DI; end
      if (port ? bus.DONE1 : bus.DONE0) begin
        got_done = 1; lat = c; err = bus.ERR; rdata = bus.RDATA;
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic run_and_check(input string tag, input bit port, input bit wr,
                               input logic [1:0] sz, input logic [AW+1:0] ad,
                               input logic [31:0] wd, input bit exp_err,
                               input logic [3:0] exp_we, input logic [AW-1:0] exp_a,
                               input logic [31:0] exp_di, input logic [31:0] exp_rd);
    bit g, d, e; logic [31:0] rd, di; int enc, lat; logic [3:0] we; logic [AW-1:0] a;
    do_txn(port, wr, sz, ad, wd, g, d, e, rd, enc, lat, we, a, di);
    check({tag, "_gnt"}, g, 1);
    check({tag, "_done"}, d, 1);
    check({tag, "_lat"}, lat, exp_err ? 2 : 3);
    check({tag, "_err"}, e, exp_err);
    check({tag, "_en_cyc"}, enc, exp_err ? 0 : 1);
    if (!exp_err) begin
      check({tag, "_a"}, a, exp_a);
      check({tag, "_we"}, we, exp_we);
      if (wr) check({tag, "_di"}, di, exp_di);
      else    check({tag, "_rdata"}, rd, exp_rd);
    end
    if (!exp_err && wr) ref_write(sz, int'(ad), wd);
  endtask

  // Grant, then assert reset so that it is sampled at the end of ACCESS (1) or RESP (2).
  task automatic abort_txn(input bit port, input bit wr, input logic [1:0] sz,
                           input logic [AW+1:0] ad, input logic [31:0] wd,
                           input int rst_at, output bit granted, output int dones);
    granted = 0; dones = 0;
    drive_req(port, wr, sz, ad, wd);
    for (int i = 0; i < 10 && !granted; i++) begin
      @(negedge CLK);
      granted = port ? bus.GNT1 : bus.GNT0;
      if (!granted) begin @(posedge CLK); #1; end
    end
    @(posedge CLK); #1;
    bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
    if (rst_at == 2) begin @(posedge CLK); #1; end
    RSTn = 1'b0;
    @(posedge CLK); #1;
    RSTn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (bus.DONE0 || bus.DONE1) dones++;
      @(posedge CLK); #1;
    end
  endtask

  typedef struct {
    bit            port;
    bit            wr;
    logic [1:0]    sz;
    logic [AW+1:0] ad;
    logic [31:0]   wd;
    bit            err;
    logic [3:0]    we;
    logic [AW-1:0] a;
    logic [31:0]   di;
    logic [31:0]   rd;
  } vec_t;

  vec_t vecs [15];
  int   gq_c[$], dq_c[$];
  bit   gq_p[$], dq_p[$];

  initial begin
    bit g; int dn;
    vecs[0]  = '{0, 1, 2'd2, 10'd0, 32'h88776655, 0, 4'hF, 8'd0, 32'h88776655, 32'h0};
    vecs[1]  = '{0, 1, 2'd0, 10'd1, 32'h000000AB, 0, 4'h2, 8'd0, 32'h0000AB00, 32'h0};
    vecs[2]  = '{0, 0, 2'd2, 10'd0, 32'h0,        0, 4'h0, 8'd0, 32'h0, 32'h8877AB55};
    vecs[3]  = '{1, 1, 2'd2, 10'd4, 32'hEEEEEEEE, 0, 4'hF, 8'd1, 32'hEEEEEEEE, 32'h0};
    vecs[4]  = '{1, 1, 2'd1, 10'd6, 32'h0000ABCD, 0, 4'hC, 8'd1, 32'hABCD0000, 32'h0};
    vecs[5]  = '{1, 0, 2'd1, 10'd6, 32'h0,        0, 4'h0, 8'd1, 32'h0, 32'h0000ABCD};
    vecs[6]  = '{0, 0, 2'd2, 10'd2, 32'h0,        1, 4'h0, 8'd0, 32'h0, 32'h0};
    vecs[7]  = '{0, 0, 2'd1, 10'd5, 32'h0,        1, 4'h0, 8'd0, 32'h0, 32'h0};
    vecs[8]  = '{1, 1, 2'd1, 10'd3, 32'h0000FFFF, 1, 4'h0, 8'd0, 32'h0, 32'h0};
    vecs[9]  = '{0, 1, 2'd3, 10'd0, 32'hFFFFFFFF, 1, 4'h0, 8'd0, 32'h0, 32'h0};
    vecs[10] = '{0, 0, 2'd2, 10'd0, 32'h0,        0, 4'h0, 8'd0, 32'h0, 32'h8877AB55};
    vecs[11] = '{0, 1, 2'd0, 10'd3, 32'hFFFFFF12, 0, 4'h8, 8'd0, 32'h12000000, 32'h0};
    vecs[12] = '{1, 0, 2'd0, 10'd3, 32'h0,        0, 4'h0, 8'd0, 32'h0, 32'h00000012};
    vecs[13] = '{0, 0, 2'd1, 10'd2, 32'h0,        0, 4'h0, 8'd0, 32'h0, 32'h00001277};
    vecs[14] = '{1, 0, 2'd2, 10'd4, 32'h0,        0, 4'h0, 8'd1, 32'h0, 32'hABCDEEEE};

    for (int i = 0; i < (1<<(AW+2)); i++) ref_mem[i] = 8'h00;
    bus.REQ0 = 1'b1; bus.REQ1 = 1'b0;
    bus.WR0 = 1'b1; bus.WR1 = 1'b0; bus.SZ0 = 2'd2; bus.SZ1 = 2'd0;
    bus.AD0 = '0; bus.AD1 = '0; bus.WD0 = 32'h12345678; bus.WD1 = '0;
    RSTn = 1'b0;
    ram_clear = 1'b1;

    // Reset held two cycles with REQ0 pending: nothing may happen.
    for (int c = 0; c < 2; c++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      check("rst_gnt0", bus.GNT0, 0);
      check("rst_done0", bus.DONE0, 0);
      check("rst_ram_en", bus.RAM_EN, 0);
      check("rst_ram_we", bus.RAM_WE, 0);
      check("rst_rdata", bus.RDATA, 0);
    end
    @(posedge CLK); #1;
    bus.REQ0 = 1'b0; RSTn = 1'b1; ram_clear = 1'b0;
    @(posedge CLK); #1;

    for (int i = 0; i < 15; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].port, vecs[i].wr, vecs[i].sz, vecs[i].ad,
                    vecs[i].wd, vecs[i].err, vecs[i].we, vecs[i].a, vecs[i].di, vecs[i].rd);

    // Both requesters held high: grants alternate 0,1,0,1 three cycles apart.
    bus.WR0 = 1'b0; bus.SZ0 = 2'd2; bus.AD0 = 10'd0;
    bus.WR1 = 1'b0; bus.SZ1 = 2'd2; bus.AD1 = 10'd4;
    bus.REQ0 = 1'b1; bus.REQ1 = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (c == 12) begin bus.REQ0 = 1'b0; bus.REQ1 = 1'b0; end
      @(negedge CLK);
      if (bus.GNT0) begin gq_c.push_back(c); gq_p.push_back(0); end
      if (bus.GNT1) begin gq_c.push_back(c); gq_p.push_back(1); end
      if (bus.DONE0) begin
        dq_c.push_back(c); dq_p.push_back(0);
        check("rr_rdata0", bus.RDATA, ref_read(2'd2, 0));
      end
      if (bus.DONE1) begin
        dq_c.push_back(c); dq_p.push_back(1);
        check("rr_rdata1", bus.RDATA, ref_read(2'd2, 4));
      end
      @(posedge CLK); #1;
    end
    check("rr_grant_cnt", gq_c.size(), 4);
    check("rr_done_cnt", dq_c.size(), 4);
    for (int i = 0; i < gq_c.size() && i < 4; i++) begin
      check($sformatf("rr_grant%0d_cyc", i), gq_c[i], 3*i);
      check($sformatf("rr_grant%0d_port", i), gq_p[i], i % 2);
    end
    for (int i = 0; i < dq_c.size() && i < 4; i++) begin
      check($sformatf("rr_done%0d_cyc", i), dq_c[i], 3*i + 3);
      check($sformatf("rr_done%0d_port", i), dq_p[i], i % 2);
    end

    // Reset sampled at the end of RESP of a read: no DONE, next read completes.
    abort_txn(0, 0, 2'd2, 10'd0, 32'h0, 2, g, dn);
    check("abort_resp_gnt", g, 1);
    check("abort_resp_dones", dn, 0);
    run_and_check("after_abort_rd", 0, 0, 2'd2, 10'd0, 32'h0, 0, 4'h0, 8'd0, 32'h0, ref_read(2'd2, 0));

    // Reset sampled at the end of ACCESS of a write: the write lands, no DONE.
    abort_txn(1, 1, 2'd2, 10'd8, 32'hCAFEF00D, 1, g, dn);
    check("abort_acc_gnt", g, 1);
    check("abort_acc_dones", dn, 0);
    ref_write(2'd2, 8, 32'hCAFEF00D);
    run_and_check("after_abort_wr", 1, 0, 2'd2, 10'd8, 32'h0, 0, 4'h0, 8'd2, 32'h0, 32'hCAFEF00D);

    // Random single-requester traffic scored against the byte model.
    for (int i = 0; i < 60; i++) begin
      bit            p  = 1'($urandom_range(0, 1));
      bit            w  = 1'($urandom_range(0, 1));
      logic [1:0]    sz = 2'($urandom_range(0, 3));
      int            ad = $urandom_range(0, 31);
      logic [31:0]   wd = $urandom;
      bit            be = ref_illegal(sz, ad);
      logic [3:0]    ew = '0;
      logic [31:0]   ed = '0;
      if (!be && w) begin
        for (int b = 0; b < (1 << sz); b++) ew[ad % 4 + b] = 1'b1;
        ed = wd << (8 * (ad % 4));
      end
      run_and_check($sformatf("rnd%0d", i), p, w, sz, 10'(ad), wd, be, ew, 8'(ad / 4), ed,
                    be ? 32'h0 : ref_read(sz, ad));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
